// File: rtl/correlation_seq_ctrl_pkg.sv
// Shared defaults and FSM encoding for the correlation sequencer.
package correlation_seq_ctrl_pkg;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_NUM_WORDS = 16;
    localparam int DEF_IDX_W     = $clog2(DEF_NUM_WORDS);
    localparam int DEF_SCORE_W   = $clog2(DEF_WORD_W + 1);
    localparam int CNT_W         = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/correlation_seq_ctrl_corr_score.sv
// Combinational match score: number of bit positions where word equals target.
module corr_score #(
    parameter int WORD_W  = 32,
    parameter int SCORE_W = 6
) (
    input  logic [WORD_W-1:0]  word,
    input  logic [WORD_W-1:0]  target,
    output logic [SCORE_W-1:0] score
);
    logic [WORD_W-1:0] w_match;

    assign w_match = ~(word ^ target);

    always_comb begin
        score = '0;
        for (int i = 0; i < WORD_W; i++)
            score = score + SCORE_W'(w_match[i]);
    end
endmodule

// File: rtl/correlation_seq_ctrl.sv
// Streams NUM_WORDS candidates, scores each against a latched target and
// reports the lowest index holding the highest score.
module correlation_seq_ctrl
    import correlation_seq_ctrl_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    localparam int IDX_W    = $clog2(NUM_WORDS),
    localparam int SCORE_W  = $clog2(WORD_W + 1)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WORD_W-1:0]  Target_Num,
    input  logic               Abort,
    input  logic               In_Valid,
    input  logic [WORD_W-1:0]  In_Data,
    output logic               In_Ready,
    input  logic               Out_Ready,
    output logic               Out_Valid,
    output logic [IDX_W-1:0]   Out_Index,
    output logic [SCORE_W-1:0] Out_Score,
    output logic               Busy
);
    state_t               r_state, w_next;
    logic [WORD_W-1:0]    r_target;
    logic [CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]     r_best_idx;
    logic [SCORE_W-1:0]   r_best_sc;
    logic [SCORE_W-1:0]   w_score;
    logic                 w_xfer;
    logic                 w_last;

    corr_score #(.WORD_W(WORD_W), .SCORE_W(SCORE_W)) u_score (
        .word   (In_Data),
        .target (r_target),
        .score  (w_score)
    );

    // A transfer coinciding with Abort is dropped.
    assign w_xfer = (r_state == ST_LOAD) && In_Valid && !Abort;
    assign w_last = (r_count == CNT_W'(NUM_WORDS - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (Start) w_next = ST_LOAD;
            ST_LOAD: begin
                if (Abort)                w_next = ST_IDLE;
                else if (w_xfer && w_last) w_next = ST_DONE;
            end
            ST_DONE: if (Out_Ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        In_Ready  = (r_state == ST_LOAD);
        Out_Valid = (r_state == ST_DONE);
        Busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_target   <= '0;
            r_count    <= '0;
            r_best_idx <= '0;
            r_best_sc  <= '0;
        end else if (r_state == ST_IDLE && Start) begin
            r_target   <= Target_Num;
            r_count    <= '0;
            r_best_idx <= '0;
            r_best_sc  <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + CNT_W'(1);
            // Strict compare keeps the earliest index on ties.
            if (r_count == '0 || w_score > r_best_sc) begin
                r_best_idx <= r_count[IDX_W-1:0];
                r_best_sc  <= w_score;
            end
        end
    end

    assign Out_Index = r_best_idx;
    assign Out_Score = r_best_sc;
endmodule

// File: tb/tb_correlation_seq_ctrl.sv
// Directed bench for correlation_seq_ctrl: hand-computed winners, stalls, abort, reset.
module tb_correlation_seq_ctrl;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] Target_Num;
    logic        Abort;
    logic        In_Valid;
    logic [31:0] In_Data;
    logic        In_Ready;
    logic        Out_Ready;
    logic        Out_Valid;
    logic [3:0]  Out_Index;
    logic [5:0]  Out_Score;
    logic        Busy;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] wv [16];

    correlation_seq_ctrl dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Target_Num(Target_Num),
        .Abort(Abort), .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .Out_Index(Out_Index),
        .Out_Score(Out_Score), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] t);
        Start = 1'b1; Target_Num = t;
        @(negedge Clock);
        Start = 1'b0; Target_Num = $urandom;
        chk("busy_load", 32'(Busy), 1);
        chk("in_ready_load", 32'(In_Ready), 1);
    endtask

    // Gap cycles also wave Start/Target_Num, which must be ignored in LOAD.
    task automatic send(input logic [31:0] w, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            In_Valid = 1'b0; In_Data = $urandom;
            Start = 1'b1; Target_Num = 32'hFFFF_FFFF;
            @(negedge Clock);
            chk("busy_gap", 32'(Busy), 1);
            chk("nvalid_gap", 32'(Out_Valid), 0);
        end
        Start = 1'b0;
        In_Valid = 1'b1; In_Data = w;
        @(negedge Clock);
        In_Valid = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [31:0] tgt, input bit gaps,
                           input logic [3:0] e_idx, input logic [5:0] e_sc, input int hold);
        start_job(tgt);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk({tag, "_early"}, 32'(Out_Valid), 0);
            send(wv[i], gaps ? int'($urandom_range(0, 3)) : 0);
        end
        chk({tag, "_valid"}, 32'(Out_Valid), 1);
        chk({tag, "_idx"}, 32'(Out_Index), 32'(e_idx));
        chk({tag, "_score"}, 32'(Out_Score), 32'(e_sc));
        chk({tag, "_nready"}, 32'(In_Ready), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge Clock);
            chk({tag, "_hold_valid"}, 32'(Out_Valid), 1);
            chk({tag, "_hold_idx"}, 32'(Out_Index), 32'(e_idx));
            chk({tag, "_hold_score"}, 32'(Out_Score), 32'(e_sc));
            chk({tag, "_hold_busy"}, 32'(Busy), 1);
        end
        Out_Ready = 1'b1;
        @(negedge Clock);
        Out_Ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(Out_Valid), 0);
        chk({tag, "_idle_busy"}, 32'(Busy), 0);
    endtask

    task automatic load_031;
        for (int i = 0; i < 16; i++) wv[i] = (i == 5) ? 32'h0 : 32'hFFFF_FFFF;
    endtask

    initial begin
        Reset = 1'b1; Start = 0; Target_Num = 0; Abort = 0;
        In_Valid = 0; In_Data = 0; Out_Ready = 0;
        repeat (2) @(negedge Clock);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_valid", 32'(Out_Valid), 0);
        chk("rst_ready", 32'(In_Ready), 0);
        chk("rst_idx", 32'(Out_Index), 0);
        chk("rst_score", 32'(Out_Score), 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Single exact match at index 5
        load_031();
        run_job("j031", 32'h0, 0, 4'd5, 6'd32, 0);

        // Tie between index 2 and 8 resolves low
        for (int i = 0; i < 16; i++) wv[i] = (i == 2 || i == 8) ? 32'h0 : 32'h1;
        run_job("j032", 32'h0, 0, 4'd2, 6'd32, 0);

        // All equal: first word wins
        for (int i = 0; i < 16; i++) wv[i] = 32'h0000_FFFF;
        run_job("j033", 32'h0, 0, 4'd0, 6'd16, 0);

        // Monotonic scores 1..16: last index wins
        for (int i = 0; i < 16; i++) wv[i] = 32'h0000_FFFF >> (15 - i);
        run_job("jlast", 32'hFFFF_FFFF, 0, 4'd15, 6'd16, 0);

        // Gaps, ignored Start/Target in LOAD, Out_Ready held low
        load_031();
        run_job("jgap", 32'h0, 1, 4'd5, 6'd32, 5);

        // Abort after 7 transfers, with a would-be transfer in the abort cycle
        start_job(32'h0);
        for (int i = 0; i < 7; i++) send(32'hFFFF_FFFF, 0);
        Abort = 1'b1; In_Valid = 1'b1; In_Data = 32'h0;
        @(negedge Clock);
        Abort = 1'b0; In_Valid = 1'b0;
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_valid", 32'(Out_Valid), 0);
        repeat (3) begin
            @(negedge Clock);
            chk("abort_nvalid", 32'(Out_Valid), 0);
        end
        load_031();
        run_job("jpost_abort", 32'h0, 0, 4'd5, 6'd32, 0);

        // Reset mid-LOAD after 10 transfers (best is index 5, score 32)
        start_job(32'h0);
        for (int i = 0; i < 10; i++) send(wv[i], 0);
        chk("pre_rst_idx", 32'(Out_Index), 5);
        Reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_ready", 32'(In_Ready), 0);
        chk("mid_rst_valid", 32'(Out_Valid), 0);
        chk("mid_rst_idx", 32'(Out_Index), 0);
        chk("mid_rst_score", 32'(Out_Score), 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        for (int i = 0; i < 16; i++) wv[i] = (i == 2 || i == 8) ? 32'h0 : 32'h1;
        run_job("jpost_rst", 32'h0, 0, 4'd2, 6'd32, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/correlation_seq_ctrl.md
CORRELATION_SEQ_CTRL -- requirements
Module: correlation_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, the candidate and target word width.
REQ-002 The block SHALL have parameter NUM_WORDS, default 16, the number of candidates per job; IDX_W = clog2(NUM_WORDS) = 4, SCORE_W = clog2(WORD_W+1) = 6.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high; ports are named Clock and Reset.
REQ-004 Clock  input  1  rising-edge system clock.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  job request, sampled in IDLE only.
REQ-007 Target_Num  input  WORD_W  target word, latched on accepted Start.
REQ-008 Abort  input  1  cancels the job in progress (LOAD only).
REQ-009 In_Valid  input  1  candidate word valid.
REQ-010 In_Data  input  WORD_W  candidate word; k-th accepted word is index k-1 (first word corresponds to Num_1).
REQ-011 In_Ready  output  1  block accepts a candidate this cycle.
REQ-012 Out_Ready  input  1  consumer accepts result.
REQ-013 Out_Valid  output  1  result valid.
REQ-014 Out_Index  output  IDX_W  index of best-correlated candidate.
REQ-015 Out_Score  output  SCORE_W  winning score.
REQ-016 Busy  output  1  high in every state except IDLE.

Function
REQ-017 Score SHALL be popcount(~(In_Data ^ Target_Latched)), range 0..32.
REQ-018 FSM states SHALL be IDLE, LOAD, DONE.
REQ-019 IDLE: Start=1 -> latch Target_Num, clear count/best, go to LOAD next cycle.
REQ-020 LOAD: In_Ready=1; transfer only when In_Valid&In_Ready; each transfer scored in that cycle and best updated at the clock edge.
REQ-021 Best SHALL be updated only when the new score is strictly greater than best, or when it is the first word; ties keep the lower index.
REQ-022 A 6-bit internal candidate counter SHALL increment per transfer; on the NUM_WORDS-th transfer the FSM enters DONE; result latency is 1 cycle after the last transfer.
REQ-023 DONE: Out_Valid=1, In_Ready=0; Out_Index/Out_Score held stable until Out_Valid&Out_Ready, then IDLE next cycle.
REQ-024 Abort=1 in LOAD -> IDLE next cycle, no Out_Valid, any transfer in that cycle discarded; Abort ignored in IDLE and DONE.
REQ-025 Start SHALL be ignored outside IDLE; Target_Num changes outside IDLE have no effect.
REQ-026 Gaps in In_Valid SHALL stall LOAD indefinitely without state change.

Reset
REQ-027 Reset SHALL force, immediately and asynchronously, state=IDLE, Out_Valid=0, In_Ready=0, Busy=0, Out_Index=0, Out_Score=0, count=0, best=0, Target_Latched=0.
REQ-028 Reset asserted mid-LOAD or mid-DONE SHALL discard the job; the first Start after deassertion begins a fresh job.

Structure
REQ-029 A shared package SHALL hold WORD_W, NUM_WORDS, IDX_W, SCORE_W defaults and the state encoding (IDLE=0, LOAD=1, DONE=2).
REQ-030 Scoring SHALL be a combinational sub-module corr_score (inputs word, target; output score), one instance.

Verification
REQ-031 Target=0, all words 0xFFFFFFFF except index 5 = 0x00000000 -> Out_Index=5, Out_Score=32, Out_Valid one cycle after the 16th transfer.
REQ-032 Target=0, words 1,1,0,1,1,1,1,1,0,1,1,1,1,1,1,1 -> Out_Index=2, Out_Score=32 (tie with index 8 resolved low).
REQ-033 Target=0, all words 0x0000FFFF -> Out_Index=0, Out_Score=16.
REQ-034 Random In_Valid gaps plus Out_Ready held low 5 cycles -> identical result to gap-free run, outputs stable while stalled, Busy high throughout.
REQ-035 Abort after 7 transfers -> IDLE next cycle, Out_Valid never asserted; the following job per REQ-031 returns index 5.
REQ-036 Reset pulse mid-LOAD (after 10 transfers) -> all outputs 0 immediately; a new job then completes correctly.
